// File: rtl/shift_normalizer_if.sv
// ============================================================================
// Module      : shift_normalizer_if
// Description : Start/done handshake and data bus of the iterative normalizer.
//               The master drives start, Dir and In. The slave (the
//               normalizer) returns busy, done, Out, Cnt and zero.
// Ports       : start  - request, sampled only while the slave is not busy
//               Dir    - 0 = normalize left (clz), 1 = normalize right (ctz)
//               In     - operand, sampled together with start
//               busy   - slave is iterating
//               done   - one-cycle pulse; Out/Cnt/zero are valid
//               Out    - normalized value
//               Cnt    - number of single-bit shifts applied
//               zero   - operand was all zeros
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface shift_normalizer_if #(
   parameter int WIDTH = 16,
   parameter int CW    = 4
);
   logic             start;
   logic             Dir;
   logic [WIDTH-1:0] In;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Out;
   logic [CW-1:0]    Cnt;
   logic             zero;

   modport master (
      output start, Dir, In,
      input  busy, done, Out, Cnt, zero
   );

   modport slave (
      input  start, Dir, In,
      output busy, done, Out, Cnt, zero
   );
endinterface

`default_nettype wire

// File: rtl/shift_normalizer.sv
// ============================================================================
// Module      : shift_normalizer
// Description : Iterative normalizer, the inverse of the barrel shifter.
//               Shifts the operand one bit per cycle until the MSB (Dir=0)
//               or the LSB (Dir=1) is set. It reports the normalized value
//               and the shift count. shifter(Out, Cnt, Dir ? 01 : 11)
//               restores the operand.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - shift_normalizer_if.slave handshake/data bus
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_normalizer #(
   parameter int WIDTH = 16,
   parameter int CW    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   shift_normalizer_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic             busy_q;
   logic             done_q;
   logic             zero_q;
   logic             dir_q;
   logic [WIDTH-1:0] out_q;
   logic [CW-1:0]    cnt_q;

   // Bit that ends the iteration, selected by the latched direction.
   logic             target_w;
   assign target_w = dir_q ? out_q[0] : out_q[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
         dir_q   <= 1'b0;
         out_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            // DONE accepts a new start just like IDLE, so back-to-back
            // operations need no idle gap.
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  out_q <= bus.In;
                  dir_q <= bus.Dir;
                  cnt_q <= '0;
                  if (bus.In == '0) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     zero_q  <= 1'b1;
                  end else begin
                     state_q <= S_SHIFT;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                     zero_q  <= 1'b0;
                  end
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end

            // A nonzero operand reaches its target bit within WIDTH-1
            // shifts, so cnt_q cannot wrap.
            S_SHIFT: begin
               if (target_w) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  out_q <= dir_q ? (out_q >> 1) : (out_q << 1);
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.Out  = out_q;
   assign bus.Cnt  = cnt_q;
   assign bus.zero = zero_q;

endmodule

`default_nettype wire
